// File: rtl/decode_stage.sv
// RV32I decode stage: DEPTH-entry instruction queue feeding a registered decode bundle.
// Optional macro DECODE_MULDIV_EN adds M-extension (funct7=0000001) recognition.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic            reg_wr,
  output logic            mem_wr,
  output logic            sel_a,
  output logic            sel_b,
  output logic [1:0]      wb_sel,
  output logic [2:0]      rd_wr_mem,
  output logic [2:0]      br_type,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] imm,
  output logic            illegal,
  output logic            is_muldiv
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] BR_NONE = 3'b010;
  localparam logic [2:0] BR_JUMP = 3'b011;
  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            reg_wr;
    logic            mem_wr;
    logic            sel_a;
    logic            sel_b;
    logic [1:0]      wb_sel;
    logic [2:0]      rd_wr_mem;
    logic [2:0]      br_type;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } bundle_t;

  function automatic logic signed [XLEN-1:0] sext_i(input logic [11:0] f);
    return {{(XLEN-12){f[11]}}, f};
  endfunction

  function automatic logic signed [XLEN-1:0] sext_b(input logic [12:1] f);
    return {{(XLEN-13){f[12]}}, f, 1'b0};
  endfunction

  function automatic logic signed [XLEN-1:0] sext_j(input logic [20:1] f);
    return {{(XLEN-21){f[20]}}, f, 1'b0};
  endfunction

  function automatic logic signed [XLEN-1:0] sext_u(input logic [31:12] f);
    return {{(XLEN-32){f[31]}}, f, 12'b0};
  endfunction

  logic [31:0]      instr_q [DEPTH];
  logic [XLEN-1:0]  pc_q    [DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] count;
  logic             full, empty, push_p0, load_p0;

  logic [31:0]      instr_p0;
  logic [6:0]       opcode_p0;
  logic [2:0]       f3_p0;
  logic [6:0]       f7_p0;
  logic             ill_p0;
  bundle_t          dec_p0;
  bundle_t          bun_p1;
  logic             vld_p1;
`ifdef DECODE_MULDIV_EN
  logic             muldiv_p0;
  logic             muldiv_p1;
`endif

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push_p0  = in_valid && !full && !flush;
  assign load_p0  = !empty && (!vld_p1 || out_ready) && !flush;

  // Stage p0: instruction queue (head is decoded combinationally)
  always_ff @(posedge clk) begin
    if (push_p0) begin
      instr_q[wptr] <= in_instr;
      pc_q[wptr]    <= in_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_p0) wptr <= wptr + 1'b1;
      if (load_p0) rptr <= rptr + 1'b1;
      unique case ({push_p0, load_p0})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign instr_p0  = instr_q[rptr];
  assign opcode_p0 = instr_p0[6:0];
  assign f3_p0     = instr_p0[14:12];
  assign f7_p0     = instr_p0[31:25];

  always_comb begin
    dec_p0           = '0;
    ill_p0           = 1'b0;
`ifdef DECODE_MULDIV_EN
    muldiv_p0        = 1'b0;
`endif
    dec_p0.pc        = pc_q[rptr];
    dec_p0.rd        = instr_p0[11:7];
    dec_p0.rs1       = instr_p0[19:15];
    dec_p0.rs2       = instr_p0[24:20];
    dec_p0.rd_wr_mem = f3_p0;
    dec_p0.br_type   = BR_NONE;
    dec_p0.wb_sel    = WB_ALU;
    unique case (opcode_p0)
      OP_R: begin
        dec_p0.reg_wr = 1'b1;
        dec_p0.alu_op = {f3_p0, instr_p0[30]};
        if (f7_p0 == 7'b0000001) begin
`ifdef DECODE_MULDIV_EN
          muldiv_p0     = 1'b1;
          dec_p0.alu_op = {f3_p0, 1'b0};
`else
          ill_p0        = 1'b1;
`endif
        end
      end
      OP_IALU: begin
        dec_p0.reg_wr = 1'b1;
        dec_p0.sel_b  = 1'b1;
        dec_p0.imm    = sext_i(instr_p0[31:20]);
        // Only shifts use bit30 as an opcode modifier; elsewhere it is immediate data.
        dec_p0.alu_op = (f3_p0 == 3'b101) ? {f3_p0, instr_p0[30]} : {f3_p0, 1'b0};
      end
      OP_LOAD: begin
        dec_p0.reg_wr = 1'b1;
        dec_p0.sel_b  = 1'b1;
        dec_p0.wb_sel = WB_MEM;
        dec_p0.imm    = sext_i(instr_p0[31:20]);
      end
      OP_STORE: begin
        dec_p0.mem_wr = 1'b1;
        dec_p0.sel_b  = 1'b1;
        dec_p0.imm    = sext_i({instr_p0[31:25], instr_p0[11:7]});
      end
      OP_BRANCH: begin
        dec_p0.sel_a   = 1'b1;
        dec_p0.sel_b   = 1'b1;
        dec_p0.br_type = f3_p0;
        dec_p0.imm     = sext_b({instr_p0[31], instr_p0[7], instr_p0[30:25], instr_p0[11:8]});
        ill_p0         = (f3_p0 == 3'b010) || (f3_p0 == 3'b011);
      end
      OP_JAL: begin
        dec_p0.reg_wr  = 1'b1;
        dec_p0.sel_a   = 1'b1;
        dec_p0.sel_b   = 1'b1;
        dec_p0.wb_sel  = WB_PC4;
        dec_p0.br_type = BR_JUMP;
        dec_p0.imm     = sext_j({instr_p0[31], instr_p0[19:12], instr_p0[20], instr_p0[30:21]});
      end
      OP_JALR: begin
        dec_p0.reg_wr  = 1'b1;
        dec_p0.sel_b   = 1'b1;
        dec_p0.wb_sel  = WB_PC4;
        dec_p0.br_type = BR_JUMP;
        dec_p0.imm     = sext_i(instr_p0[31:20]);
      end
      OP_LUI: begin
        dec_p0.reg_wr = 1'b1;
        dec_p0.sel_b  = 1'b1;
        dec_p0.rs1    = 5'd0;
        dec_p0.imm    = sext_u(instr_p0[31:12]);
      end
      OP_AUIPC: begin
        dec_p0.reg_wr = 1'b1;
        dec_p0.sel_a  = 1'b1;
        dec_p0.sel_b  = 1'b1;
        dec_p0.imm    = sext_u(instr_p0[31:12]);
      end
      default: ill_p0 = 1'b1;
    endcase
    // Illegal encodings become a side-effect-free bubble that execute can trap on.
    if (ill_p0) begin
      dec_p0.reg_wr  = 1'b0;
      dec_p0.mem_wr  = 1'b0;
      dec_p0.sel_a   = 1'b0;
      dec_p0.sel_b   = 1'b0;
      dec_p0.wb_sel  = WB_ALU;
      dec_p0.alu_op  = 4'd0;
      dec_p0.br_type = BR_NONE;
      dec_p0.imm     = '0;
    end
    dec_p0.illegal = ill_p0;
    if (dec_p0.rd == 5'd0) dec_p0.reg_wr = 1'b0;
  end

  // Stage p1: registered decode bundle toward execute
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      bun_p1 <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (load_p0) begin
      vld_p1 <= 1'b1;
      bun_p1 <= dec_p0;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

`ifdef DECODE_MULDIV_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       muldiv_p1 <= 1'b0;
    else if (load_p0) muldiv_p1 <= muldiv_p0;
  end
  assign is_muldiv = muldiv_p1;
`else
  assign is_muldiv = 1'b0;
`endif

  assign out_valid = vld_p1;
  assign out_pc    = bun_p1.pc;
  assign rd        = bun_p1.rd;
  assign rs1       = bun_p1.rs1;
  assign rs2       = bun_p1.rs2;
  assign reg_wr    = bun_p1.reg_wr;
  assign mem_wr    = bun_p1.mem_wr;
  assign sel_a     = bun_p1.sel_a;
  assign sel_b     = bun_p1.sel_b;
  assign wb_sel    = bun_p1.wb_sel;
  assign rd_wr_mem = bun_p1.rd_wr_mem;
  assign br_type   = bun_p1.br_type;
  assign alu_op    = bun_p1.alu_op;
  assign imm       = bun_p1.imm;
  assign illegal   = bun_p1.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with an expected-bundle scoreboard.
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, imm;
  logic [4:0]  rd, rs1, rs2;
  logic        reg_wr, mem_wr, sel_a, sel_b, illegal, is_muldiv;
  logic [1:0]  wb_sel;
  logic [2:0]  rd_wr_mem, br_type;
  logic [3:0]  alu_op;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .rd(rd), .rs1(rs1), .rs2(rs2), .reg_wr(reg_wr), .mem_wr(mem_wr),
    .sel_a(sel_a), .sel_b(sel_b), .wb_sel(wb_sel), .rd_wr_mem(rd_wr_mem),
    .br_type(br_type), .alu_op(alu_op), .imm(imm), .illegal(illegal), .is_muldiv(is_muldiv)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic        rw, mw, sa, sb;
    logic [1:0]  wb;
    logic [2:0]  f3, br;
    logic [3:0]  alu;
    logic [31:0] imm;
    logic        ill, md;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic [31:0] ins_t[14];
  exp_t        e_t[14];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] d, s1, s2,
                              input logic rw, mw, sa, sb, input logic [1:0] wb,
                              input logic [2:0] f3, br, input logic [3:0] alu,
                              input logic [31:0] im, input logic ill, md);
    return {pc, d, s1, s2, rw, mw, sa, sb, wb, f3, br, alu, im, ill, md};
  endfunction

  function automatic exp_t cur();
    return {out_pc, rd, rs1, rs2, reg_wr, mem_wr, sel_a, sel_b, wb_sel, rd_wr_mem,
            br_type, alu_op, imm, illegal, is_muldiv};
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chkb(input string tag, input exp_t obs, input exp_t exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h (pc %h vs %h)", tag, obs, exp, obs.pc, exp.pc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input exp_t e);
    int t;
    t = 0;
    in_instr = ins;
    in_pc    = e.pc;
    in_valid = 1'b1;
    while (!in_ready && t < 40) begin
      tick();
      t++;
    end
    chk1("send_ready", in_ready, 1'b1);
    if (in_ready) exp_q.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  // Scoreboard consumer: a bundle is taken by execute when valid && ready at the next edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk1("sb_extra_valid", out_valid, 1'b0);
      else chkb("sb_bundle", cur(), exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int   cs;
    ins_t[0]  = 32'h0080A103; e_t[0]  = mk(0, 2, 1, 8, 1, 0, 0, 1, 2'd1, 3'd2, 3'd2, 4'd0, 32'd8, 0, 0);
    ins_t[1]  = 32'hFE20AE23; e_t[1]  = mk(0, 28, 1, 2, 0, 1, 0, 1, 2'd0, 3'd2, 3'd2, 4'd0, 32'hFFFFFFFC, 0, 0);
    ins_t[2]  = 32'hFE208CE3; e_t[2]  = mk(0, 25, 1, 2, 0, 0, 1, 1, 2'd0, 3'd0, 3'd0, 4'd0, 32'hFFFFFFF8, 0, 0);
    ins_t[3]  = 32'h123451B7; e_t[3]  = mk(0, 3, 0, 3, 1, 0, 0, 1, 2'd0, 3'd5, 3'd2, 4'd0, 32'h12345000, 0, 0);
    ins_t[4]  = 32'h40628233; e_t[4]  = mk(0, 4, 5, 6, 1, 0, 0, 0, 2'd0, 3'd0, 3'd2, 4'b0001, 32'd0, 0, 0);
    ins_t[5]  = 32'h4030D093; e_t[5]  = mk(0, 1, 1, 3, 1, 0, 0, 1, 2'd0, 3'd5, 3'd2, 4'b1011, 32'h403, 0, 0);
    ins_t[6]  = 32'h40000093; e_t[6]  = mk(0, 1, 0, 0, 1, 0, 0, 1, 2'd0, 3'd0, 3'd2, 4'b0000, 32'h400, 0, 0);
    ins_t[7]  = 32'h00000013; e_t[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 3'd0, 3'd2, 4'd0, 32'd0, 0, 0);
    ins_t[8]  = 32'h010000EF; e_t[8]  = mk(0, 1, 0, 16, 1, 0, 1, 1, 2'd2, 3'd0, 3'd3, 4'd0, 32'd16, 0, 0);
    ins_t[9]  = 32'h00008067; e_t[9]  = mk(0, 0, 1, 0, 0, 0, 0, 1, 2'd2, 3'd0, 3'd3, 4'd0, 32'd0, 0, 0);
    ins_t[10] = 32'h00001297; e_t[10] = mk(0, 5, 0, 0, 1, 0, 1, 1, 2'd0, 3'd1, 3'd2, 4'd0, 32'h1000, 0, 0);
`ifdef DECODE_MULDIV_EN
    ins_t[11] = 32'h027302B3; e_t[11] = mk(0, 5, 6, 7, 1, 0, 0, 0, 2'd0, 3'd0, 3'd2, 4'd0, 32'd0, 0, 1);
`else
    ins_t[11] = 32'h027302B3; e_t[11] = mk(0, 5, 6, 7, 0, 0, 0, 0, 2'd0, 3'd0, 3'd2, 4'd0, 32'd0, 1, 0);
`endif
    ins_t[12] = 32'h0000007F; e_t[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 3'd0, 3'd2, 4'd0, 32'd0, 1, 0);
    ins_t[13] = 32'h0020A063; e_t[13] = mk(0, 0, 1, 2, 0, 0, 0, 0, 2'd0, 3'd2, 3'd2, 4'd0, 32'd0, 1, 0);

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    #3;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    chkb("rst_bundle", cur(), '0);
    @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
    tick();
    chk1("post_rst_in_ready", in_ready, 1'b1);
    chk1("post_rst_out_valid", out_valid, 1'b0);

    // addi x1,x0,5: accepted at edge k, visible after edge k+1
    out_ready = 1'b1;
    send(32'h00500093, mk(32'h1000, 1, 0, 5, 1, 0, 0, 1, 2'd0, 3'd0, 3'd2, 4'd0, 32'd5, 0, 0));
    chk1("lat_after_k", out_valid, 1'b0);
    tick();
    chk1("lat_after_k1", out_valid, 1'b1);
    tick();
    chk32("lat_drain", exp_q.size(), 0);

    // Back-to-back stream at full throughput
    cs = cyc;
    for (int i = 0; i < 14; i++) begin
      e = e_t[i];
      e.pc = 32'h2000 + 32'(4 * i);
      send(ins_t[i], e);
    end
    chk32("tput_cycles", cyc - cs, 14);
    tick(); tick(); tick();
    chk32("tput_drain", exp_q.size(), 0);
    chk1("tput_idle", out_valid, 1'b0);

    // Backpressure: 1 held in output + 4 queued
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      e = e_t[i];
      e.pc = 32'h3000 + 32'(4 * i);
      send(ins_t[i], e);
    end
    chk1("bp_in_ready", in_ready, 1'b0);
    chkb("bp_hold0", cur(), exp_q[0]);
    in_valid = 1'b1; in_instr = ins_t[5]; in_pc = 32'h3FFC;
    tick(); tick(); tick();
    chk1("bp_still_full", in_ready, 1'b0);
    chk1("bp_valid", out_valid, 1'b1);
    chkb("bp_hold3", cur(), exp_q[0]);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    chk32("bp_drain", exp_q.size(), 0);
    chk1("bp_empty", out_valid, 1'b0);

    // Flush with 3 queued and a simultaneous push
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e = e_t[i];
      e.pc = 32'h4000 + 32'(4 * i);
      send(ins_t[i], e);
    end
    chk1("fl_pre_valid", out_valid, 1'b1);
    in_valid = 1'b1; in_instr = ins_t[6]; in_pc = 32'h4DEC; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    chk1("fl_valid", out_valid, 1'b0);
    chk1("fl_in_ready", in_ready, 1'b1);
    tick(); tick();
    chk1("fl_queue_empty", out_valid, 1'b0);
    out_ready = 1'b1;
    e = e_t[3];
    e.pc = 32'h5000;
    send(ins_t[3], e);
    tick(); tick();
    chk32("fl_drain", exp_q.size(), 0);

    // Asynchronous reset in the middle of a cycle
    out_ready = 1'b0;
    e = e_t[0]; e.pc = 32'h6000; send(ins_t[0], e);
    e = e_t[1]; e.pc = 32'h6004; send(ins_t[1], e);
    chk1("mrst_pre_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("mrst_valid", out_valid, 1'b0);
    chkb("mrst_bundle", cur(), '0);
    exp_q.delete();
    @(posedge clk); #2 rst_n = 1'b1;
    tick(); tick();
    chk1("mrst_queue_empty", out_valid, 1'b0);
    chk1("mrst_in_ready", in_ready, 1'b1);

    chk32("sb_final", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
